// File: rtl/hyper_lsab_dram_mc.sv
// Page-aware block mover controller: splits a transfer at page ends, requests
// channel alignment, issues one chunk at a time to an external mover.
module hyper_lsab_dram_mc #(
    parameter int ADDR_W   = 32,
    parameter int PAGE_W   = 12,
    parameter int LEN_W    = 6,
    parameter int NDRAM    = 2,
    parameter int DSEL_LSB = 12
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     GO,
    input  logic                     AUTO_CONT,
    input  logic [LEN_W-1:0]         BLOCK_LENGTH,
    input  logic [ADDR_W-1:0]        NEW_ADDR,
    input  logic [1:0]               NEW_SECTION,
    output logic [ADDR_W-1:0]        OLD_ADDR,
    output logic                     READY,
    output logic                     ENDOF_PAGE,
    output logic                     SHORT,
    output logic [PAGE_W-1:0]        BLCK_START,
    output logic [LEN_W-1:0]         BLCK_COUNT_REQ,
    output logic                     BLCK_ISSUE,
    output logic [1:0]               BLCK_SECTION,
    input  logic [LEN_W-1:0]         BLCK_COUNT_SENT,
    input  logic                     BLCK_WORKING,
    output logic [ADDR_W-PAGE_W-1:0] MCU_PAGE_ADDR,
    output logic [NDRAM-1:0]         MCU_REQUEST_ALIGN,
    input  logic [NDRAM-1:0]         MCU_GRANT_ALIGN
);
    localparam int DSEL = (NDRAM > 1) ? $clog2(NDRAM) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, SIZE, ISSUE, MOVE, CLOSE} state_e;

    state_e                    state_q, state_d;
    logic [ADDR_W-1:0]         cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0]          rem_q, rem_d;
    logic                      auto_q, auto_d;
    logic [1:0]                section_q, section_d;
    logic [ADDR_W-1:0]         old_addr_q, old_addr_d;
    logic                      eop_q, eop_d;
    logic                      short_q, short_d;
    logic [PAGE_W-1:0]         start_q, start_d;
    logic [LEN_W-1:0]          count_req_q, count_req_d;
    logic                      issue_q, issue_d;
    logic [ADDR_W-PAGE_W-1:0]  page_q, page_d;
    logic [NDRAM-1:0]          req_align_q, req_align_d;
    logic                      working_q;
    logic [LEN_W-1:0]          sent_q, sent_d;

    logic [NDRAM-1:0]          chan_onehot;
    logic [PAGE_W:0]           end_sum;
    logic [PAGE_W:0]           to_page_end;
    logic [LEN_W-1:0]          sent_eff;
    logic                      grant_ok;
    logic                      working_fall;

    generate
        if (NDRAM > 1) begin : g_multi
            assign chan_onehot = NDRAM'(1) << cur_addr_q[DSEL_LSB +: DSEL];
        end else begin : g_single
            assign chan_onehot = 1'b1;
        end
    endgenerate

    // Carry out of bit PAGE_W means the chunk would cross the page end.
    assign end_sum      = {1'b0, start_q} + (PAGE_W+1)'(rem_q);
    assign to_page_end  = {1'b1, {PAGE_W{1'b0}}} - {1'b0, start_q};
    assign sent_eff     = (BLCK_COUNT_SENT > count_req_q) ? count_req_q : BLCK_COUNT_SENT;
    // Mover handshake: a chunk starts with the one-cycle BLCK_ISSUE pulse, only
    // while the mover is idle (now and last cycle); it ends when BLCK_WORKING falls.
    assign grant_ok     = (|(MCU_GRANT_ALIGN & req_align_q)) && !BLCK_WORKING && !working_q;
    assign working_fall = working_q && !BLCK_WORKING;

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        rem_d       = rem_q;
        auto_d      = auto_q;
        section_d   = section_q;
        old_addr_d  = old_addr_q;
        eop_d       = eop_q;
        short_d     = short_q;
        start_d     = start_q;
        count_req_d = count_req_q;
        issue_d     = 1'b0;
        page_d      = page_q;
        req_align_d = req_align_q;
        sent_d      = sent_q;
        case (state_q)
            IDLE: begin
                if (GO) begin
                    state_d     = LOAD;
                    cur_addr_d  = NEW_ADDR;
                    rem_d       = BLOCK_LENGTH;
                    auto_d      = AUTO_CONT;
                    section_d   = NEW_SECTION;
                    eop_d       = 1'b0;
                    short_d     = 1'b0;
                    sent_d      = '0;
                    count_req_d = '0;
                end
            end
            LOAD: begin
                if (rem_q == '0) begin
                    state_d = CLOSE;
                end else begin
                    page_d      = cur_addr_q[ADDR_W-1:PAGE_W];
                    start_d     = cur_addr_q[PAGE_W-1:0];
                    req_align_d = chan_onehot;
                    state_d     = SIZE;
                end
            end
            SIZE: begin
                count_req_d = end_sum[PAGE_W] ? LEN_W'(to_page_end) : rem_q;
                state_d     = ISSUE;
            end
            ISSUE: begin
                if (grant_ok) begin
                    issue_d = 1'b1;
                    state_d = MOVE;
                end
            end
            MOVE: begin
                if (working_fall) begin
                    cur_addr_d  = cur_addr_q + ADDR_W'(sent_eff);
                    rem_d       = rem_q - sent_eff;
                    sent_d      = sent_eff;
                    req_align_d = '0;
                    state_d     = CLOSE;
                end
            end
            CLOSE: begin
                if (sent_q < count_req_q) begin
                    short_d = 1'b1;
                    state_d = IDLE;
                end else if (rem_q == '0) begin
                    state_d = IDLE;
                end else if (auto_q) begin
                    state_d = LOAD;
                end else begin
                    eop_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d == IDLE && state_q != IDLE) old_addr_d = cur_addr_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            rem_q       <= '0;
            auto_q      <= 1'b0;
            section_q   <= '0;
            old_addr_q  <= '0;
            eop_q       <= 1'b0;
            short_q     <= 1'b0;
            start_q     <= '0;
            count_req_q <= '0;
            issue_q     <= 1'b0;
            page_q      <= '0;
            req_align_q <= '0;
            working_q   <= 1'b0;
            sent_q      <= '0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            rem_q       <= rem_d;
            auto_q      <= auto_d;
            section_q   <= section_d;
            old_addr_q  <= old_addr_d;
            eop_q       <= eop_d;
            short_q     <= short_d;
            start_q     <= start_d;
            count_req_q <= count_req_d;
            issue_q     <= issue_d;
            page_q      <= page_d;
            req_align_q <= req_align_d;
            working_q   <= BLCK_WORKING;
            sent_q      <= sent_d;
        end
    end

    assign READY             = (state_q == IDLE);
    assign OLD_ADDR          = old_addr_q;
    assign ENDOF_PAGE        = eop_q;
    assign SHORT             = short_q;
    assign BLCK_START        = start_q;
    assign BLCK_COUNT_REQ    = count_req_q;
    assign BLCK_ISSUE        = issue_q;
    assign BLCK_SECTION      = section_q;
    assign MCU_PAGE_ADDR     = page_q;
    assign MCU_REQUEST_ALIGN = req_align_q;

endmodule

// File: tb/tb_hyper_lsab_dram_mc.sv
// Bench for hyper_lsab_dram_mc: vector table, randomized transfers against a
// chunk-list model, and hand sequences for stalls, reset and a 1-channel build.
module tb_hyper_lsab_dram_mc;
    localparam int ADDR_W = 32;
    localparam int PAGE_W = 12;
    localparam int LEN_W  = 6;
    localparam int NDRAM  = 2;
    localparam int PAGE   = 1 << PAGE_W;
    localparam int CW     = (ADDR_W - PAGE_W) + PAGE_W + LEN_W + NDRAM;
    localparam int CW8    = 24 + 8 + LEN_W + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst, go, auto_cont, ready, eop, short_f, blck_issue, working;
    logic [LEN_W-1:0]         blen, count_req, cnt_sent;
    logic [ADDR_W-1:0]        new_addr, old_addr;
    logic [1:0]               new_sec, blck_section;
    logic [PAGE_W-1:0]        blck_start;
    logic [ADDR_W-PAGE_W-1:0] page_addr;
    logic [NDRAM-1:0]         req_align, grant;

    logic                     go8, ac8, ready8, eop8, short8, issue8, working8;
    logic [LEN_W-1:0]         blen8, count_req8, cnt_sent8;
    logic [ADDR_W-1:0]        new_addr8, old_addr8;
    logic [1:0]               sec8, section8;
    logic [7:0]               start8;
    logic [23:0]              page8;
    logic [0:0]               align8, grant8;

    hyper_lsab_dram_mc u_dut (
        .CLK(clk), .RST(rst), .GO(go), .AUTO_CONT(auto_cont), .BLOCK_LENGTH(blen),
        .NEW_ADDR(new_addr), .NEW_SECTION(new_sec), .OLD_ADDR(old_addr), .READY(ready),
        .ENDOF_PAGE(eop), .SHORT(short_f), .BLCK_START(blck_start), .BLCK_COUNT_REQ(count_req),
        .BLCK_ISSUE(blck_issue), .BLCK_SECTION(blck_section), .BLCK_COUNT_SENT(cnt_sent),
        .BLCK_WORKING(working), .MCU_PAGE_ADDR(page_addr), .MCU_REQUEST_ALIGN(req_align),
        .MCU_GRANT_ALIGN(grant)
    );

    hyper_lsab_dram_mc #(.ADDR_W(32), .PAGE_W(8), .LEN_W(6), .NDRAM(1), .DSEL_LSB(8)) u_dut8 (
        .CLK(clk), .RST(rst), .GO(go8), .AUTO_CONT(ac8), .BLOCK_LENGTH(blen8),
        .NEW_ADDR(new_addr8), .NEW_SECTION(sec8), .OLD_ADDR(old_addr8), .READY(ready8),
        .ENDOF_PAGE(eop8), .SHORT(short8), .BLCK_START(start8), .BLCK_COUNT_REQ(count_req8),
        .BLCK_ISSUE(issue8), .BLCK_SECTION(section8), .BLCK_COUNT_SENT(cnt_sent8),
        .BLCK_WORKING(working8), .MCU_PAGE_ADDR(page8), .MCU_REQUEST_ALIGN(align8),
        .MCU_GRANT_ALIGN(grant8)
    );

    int total = 0;
    int bad   = 0;
    int mover_ret = -1;
    logic [LEN_W-1:0] req_cnt, req_cnt8;
    logic [CW-1:0]  exp_q[$];
    logic [CW-1:0]  act_q[$];
    logic [CW8-1:0] act8_q[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Mover: answers each issue after a short busy period with mover_ret words
    // (or the full request when mover_ret is negative).
    initial begin
        working = 1'b0;
        cnt_sent = '0;
        forever begin
            @(negedge clk);
            if (blck_issue === 1'b1) begin
                act_q.push_back({page_addr, blck_start, count_req, req_align});
                req_cnt = count_req;
                @(negedge clk);
                check("issue_one_cycle", 64'(blck_issue), 64'(0));
                working = 1'b1;
                repeat (2) @(negedge clk);
                cnt_sent = (mover_ret < 0) ? req_cnt : LEN_W'(mover_ret);
                working = 1'b0;
            end
        end
    end

    initial begin
        working8 = 1'b0;
        cnt_sent8 = '0;
        forever begin
            @(negedge clk);
            if (issue8 === 1'b1) begin
                act8_q.push_back({page8, start8, count_req8, align8});
                req_cnt8 = count_req8;
                @(negedge clk);
                working8 = 1'b1;
                repeat (3) @(negedge clk);
                cnt_sent8 = req_cnt8;
                working8 = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("align_onehot0", 64'($onehot0(req_align)), 64'(1));
            if (ready) check("align_zero_idle", 64'(req_align), 64'(0));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: walk the transfer page by page, recording each expected chunk.
    task automatic model(input logic [31:0] a, input int len, input bit ac, input int ret,
                         output logic [31:0] old, output bit m_eop, output bit m_sh);
        logic [31:0] addr;
        int rem, off, room, chunk, got;
        logic [NDRAM-1:0] ch;
        addr = a;
        rem = len;
        m_eop = 1'b0;
        m_sh = 1'b0;
        while (rem > 0) begin
            off = int'(addr % 32'(PAGE));
            room = PAGE - off;
            chunk = (rem < room) ? rem : room;
            got = (ret < 0 || ret > chunk) ? chunk : ret;
            ch = (((addr / 32'(PAGE)) % 32'd2) == 32'd1) ? 2'b10 : 2'b01;
            exp_q.push_back({20'(addr / 32'(PAGE)), 12'(off), 6'(chunk), ch});
            addr = addr + 32'(got);
            rem = rem - got;
            if (got < chunk) begin
                m_sh = 1'b1;
                break;
            end
            if (rem > 0 && !ac) begin
                m_eop = 1'b1;
                break;
            end
        end
        old = addr;
    endtask

    task automatic compare_chunks(input string nm);
        check({nm, "_nchunks"}, 64'(act_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && act_q.size() > 0)
            check({nm, "_chunk"}, 64'(act_q.pop_front()), 64'(exp_q.pop_front()));
        act_q.delete();
        exp_q.delete();
    endtask

    // Starts at a negedge with READY high; returns GO-to-issue latency in cycles.
    task automatic run_txn(input logic [31:0] a, input int len, input bit ac, input int ret,
                           input logic [1:0] sec, output int lat);
        int k;
        lat = -1;
        new_addr = a;
        blen = LEN_W'(len);
        auto_cont = ac;
        new_sec = sec;
        mover_ret = ret;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        k = 1;
        while (ready !== 1'b1 && k < 400) begin
            if (blck_issue === 1'b1 && lat < 0) lat = k - 1;
            @(negedge clk);
            k++;
        end
        check("ready_return", 64'(k < 400), 64'(1));
        check("section", 64'(blck_section), 64'(sec));
    endtask

    typedef struct {
        logic [31:0]   addr;
        int            len;
        bit            ac;
        int            ret;
        logic [31:0]   exp_old;
        bit            exp_eop;
        bit            exp_short;
        int            exp_n;
        logic [CW-1:0] exp_first;
        logic [CW-1:0] exp_second;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int lat, k;
        logic [31:0] m_old, a;
        bit m_eop, m_sh, ac;
        int len, ret;

        vecs[0] = '{32'h0000_1F00, 32, 1'b0, -1, 32'h0000_1F20, 1'b0, 1'b0, 1,
                    {20'h00001, 12'hF00, 6'd32, 2'b10}, '0};
        vecs[1] = '{32'h0000_0FF0, 40, 1'b1, -1, 32'h0000_1018, 1'b0, 1'b0, 2,
                    {20'h00000, 12'hFF0, 6'd16, 2'b01}, {20'h00001, 12'h000, 6'd24, 2'b10}};
        vecs[2] = '{32'h0000_0FF0, 40, 1'b0, -1, 32'h0000_1000, 1'b1, 1'b0, 1,
                    {20'h00000, 12'hFF0, 6'd16, 2'b01}, '0};
        vecs[3] = '{32'h0000_2004, 20, 1'b0, 12, 32'h0000_2010, 1'b0, 1'b1, 1,
                    {20'h00002, 12'h004, 6'd20, 2'b01}, '0};
        vecs[4] = '{32'h1234_5678, 0, 1'b1, -1, 32'h1234_5678, 1'b0, 1'b0, 0, '0, '0};
        vecs[5] = '{32'h0000_3000, 10, 1'b0, 50, 32'h0000_300A, 1'b0, 1'b0, 1,
                    {20'h00003, 12'h000, 6'd10, 2'b10}, '0};

        rst = 1'b1; go = 1'b0; auto_cont = 1'b0; blen = '0; new_addr = '0; new_sec = '0;
        grant = '1;
        go8 = 1'b0; ac8 = 1'b0; blen8 = '0; new_addr8 = '0; sec8 = 2'b01; grant8 = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_ready", 64'(ready), 64'(1));
        check("rst_issue", 64'(blck_issue), 64'(0));
        check("rst_align", 64'(req_align), 64'(0));
        check("rst_old", 64'(old_addr), 64'(0));
        check("rst_flags", 64'({eop, short_f}), 64'(0));
        check("rst_count_req", 64'(count_req), 64'(0));
        check("rst_ready8", 64'(ready8), 64'(1));
        rst = 1'b0;

        // Table: first vector issues GO in the very first cycle after reset.
        for (int i = 0; i < 6; i++) begin
            model(vecs[i].addr, vecs[i].len, vecs[i].ac, vecs[i].ret, m_old, m_eop, m_sh);
            run_txn(vecs[i].addr, vecs[i].len, vecs[i].ac, vecs[i].ret, 2'(i), lat);
            check("vec_old", 64'(old_addr), 64'(vecs[i].exp_old));
            check("vec_eop", 64'(eop), 64'(vecs[i].exp_eop));
            check("vec_short", 64'(short_f), 64'(vecs[i].exp_short));
            check("vec_nissue", 64'(act_q.size()), 64'(vecs[i].exp_n));
            if (vecs[i].exp_n > 0) begin
                check("vec_latency", 64'(lat), 64'(3));
                check("vec_first", (act_q.size() > 0) ? 64'(act_q[0]) : 64'hDEAD, 64'(vecs[i].exp_first));
            end
            if (vecs[i].exp_n > 1)
                check("vec_second", (act_q.size() > 1) ? 64'(act_q[1]) : 64'hDEAD, 64'(vecs[i].exp_second));
            compare_chunks("vec");
        end

        // Randomized transfers, half of them starting near a page end.
        for (int i = 0; i < 40; i++) begin
            a = $urandom();
            if ($urandom_range(0, 1) == 1) a = (a & 32'hFFFF_F000) | 32'(PAGE - $urandom_range(1, 63));
            len = $urandom_range(0, 63);
            ac = 1'($urandom_range(0, 1));
            ret = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : -1;
            model(a, len, ac, ret, m_old, m_eop, m_sh);
            run_txn(a, len, ac, ret, 2'($urandom_range(0, 3)), lat);
            check("rnd_old", 64'(old_addr), 64'(m_old));
            check("rnd_eop", 64'(eop), 64'(m_eop));
            check("rnd_short", 64'(short_f), 64'(m_sh));
            if (len > 0) check("rnd_latency", 64'(lat), 64'(3));
            compare_chunks("rnd");
        end

        // Grant withheld: request held, no issue, GO ignored while busy.
        m_old = old_addr;
        grant = '0;
        model(32'h0000_5010, 8, 1'b0, -1, a, m_eop, m_sh);
        new_addr = 32'h0000_5010; blen = 6'd8; auto_cont = 1'b0; mover_ret = -1; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (4) @(negedge clk);
        new_addr = 32'h0000_9000; blen = 6'd30; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (5) @(negedge clk);
        check("stall_no_issue", 64'(act_q.size()), 64'(0));
        check("stall_ready", 64'(ready), 64'(0));
        check("stall_align", 64'(req_align), 64'(2'b10));
        check("stall_count_req", 64'(count_req), 64'(8));
        check("stall_old_hold", 64'(old_addr), 64'(m_old));
        grant = '1;
        k = 0;
        while (ready !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("stall_ready_return", 64'(k < 400), 64'(1));
        check("stall_old", 64'(old_addr), 64'(32'h0000_5018));
        compare_chunks("stall");

        // Reset while the mover is busy.
        new_addr = 32'h0000_6000; blen = 6'd16; auto_cont = 1'b1; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        k = 0;
        while (blck_issue !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("move_reached", 64'(k < 50), 64'(1));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_move_ready", 64'(ready), 64'(1));
        check("rst_move_align", 64'(req_align), 64'(0));
        check("rst_move_issue", 64'(blck_issue), 64'(0));
        check("rst_move_old", 64'(old_addr), 64'(0));
        rst = 1'b0;
        repeat (6) @(negedge clk);
        act_q.delete();
        exp_q.delete();
        model(32'h0000_7FFC, 12, 1'b1, -1, m_old, m_eop, m_sh);
        run_txn(32'h0000_7FFC, 12, 1'b1, -1, 2'b11, lat);
        check("post_rst_old", 64'(old_addr), 64'(32'h0000_8008));
        compare_chunks("post_rst");

        // Single-channel, 256-byte pages, transfer wrapping the address space.
        new_addr8 = 32'hFFFF_FFFC; blen8 = 6'd8; ac8 = 1'b1; go8 = 1'b1;
        @(negedge clk);
        go8 = 1'b0;
        k = 0;
        while (ready8 !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("n1_ready_return", 64'(k < 400), 64'(1));
        check("n1_nissue", 64'(act8_q.size()), 64'(2));
        check("n1_first", (act8_q.size() > 0) ? 64'(act8_q[0]) : 64'hDEAD,
              64'({24'hFF_FFFF, 8'hFC, 6'd4, 1'b1}));
        check("n1_second", (act8_q.size() > 1) ? 64'(act8_q[1]) : 64'hDEAD,
              64'({24'h00_0000, 8'h00, 6'd4, 1'b1}));
        check("n1_old", 64'(old_addr8), 64'(32'h0000_0004));
        check("n1_flags", 64'({eop8, short8}), 64'(0));
        check("n1_section", 64'(section8), 64'(2'b01));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
